// File: rtl/tt_adder_driver.sv
// tt_adder_driver: valid/ready driver that applies operands to an external adder, samples its sum after LATENCY+1 edges and checks it.
// Ports: clk, rst_n (sync, active-low) | cmd_valid/cmd_ready/cmd_a/cmd_b command in
//        op_a/op_b operands out, res_in adder sum in | rsp_valid/rsp_ready/rsp_sum/rsp_carry/rsp_mismatch response out
//        err_clr/err_count mismatch counter (only with ADDER_DRV_ERRCNT_EN defined, else constant 0) | busy
module tt_adder_driver #(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  input  logic [7:0] res_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_sum,
  output logic       rsp_carry,
  output logic       rsp_mismatch,
  input  logic       err_clr,
  output logic [7:0] err_count,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t     state_q;
  logic [7:0] op_a_q, op_b_q, rsp_sum_q;
  logic [3:0] cnt_q;
  logic       rsp_valid_q, rsp_carry_q, rsp_mismatch_q;
  logic [8:0] sum_d;
  logic       sample_d, mismatch_d;
  // op_a_q/op_b_q double as the latched command operands
  assign sum_d      = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign sample_d   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mismatch_d = res_in != sum_d[7:0];
  // gated by rst_n so it is low during reset and high as soon as reset is released
  assign cmd_ready    = rst_n && (state_q == IDLE);
  assign busy         = state_q != IDLE;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_mismatch = rsp_mismatch_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q        <= IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      cnt_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_sum_q      <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_mismatch_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (cmd_valid) begin
        op_a_q  <= cmd_a;
        op_b_q  <= cmd_b;
        cnt_q   <= 4'(LATENCY);
        state_q <= WAIT;
      end
    end else if (state_q == WAIT) begin
      if (sample_d) begin
        rsp_sum_q      <= res_in;
        rsp_carry_q    <= sum_d[8];
        rsp_mismatch_q <= mismatch_d;
        rsp_valid_q    <= 1'b1;
        state_q        <= RESP;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
      state_q     <= IDLE;
    end
`ifdef ADDER_DRV_ERRCNT_EN
  logic [7:0] err_q;
  // clear wins over a coincident increment
  always_ff @(posedge clk)
    if (!rst_n || err_clr) err_q <= '0;
    else if (sample_d && mismatch_d && err_q != 8'hFF) err_q <= err_q + 8'd1;
  assign err_count = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif
endmodule

// File: doc/tt_adder_driver.md
TT_ADDER_DRIVER -- requirements
Module: tt_adder_driver

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1, meaning the DUT register stages between operand drive and result (legal 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid  input  1  command request.
REQ-005 The block SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 The block SHALL have port cmd_a  input  8  operand A.
REQ-007 The block SHALL have port cmd_b  input  8  operand B.
REQ-008 The block SHALL have port op_a  output  8  operand A to the adder's ui_in.
REQ-009 The block SHALL have port op_b  output  8  operand B to the adder's uio_in.
REQ-010 The block SHALL have port res_in  input  8  sum from the adder's uo_out.
REQ-011 The block SHALL have port rsp_valid  output  1  response available.
REQ-012 The block SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 The block SHALL have port rsp_sum  output  8  sampled res_in.
REQ-014 The block SHALL have port rsp_carry  output  1  bit 8 of cmd_a+cmd_b.
REQ-015 The block SHALL have port rsp_mismatch  output  1  sampled res_in differs from (cmd_a+cmd_b) mod 256.
REQ-016 The block SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-017 The block SHALL have port err_count  output  8  saturating mismatch counter.
REQ-018 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT, RESP; cmd_ready SHALL be high only in IDLE.
REQ-020 On edge E0 with cmd_valid&cmd_ready: latch cmd_a/cmd_b, register op_a/op_b from them, load wait counter with LATENCY, enter WAIT.
REQ-021 In WAIT the counter SHALL decrement each cycle; res_in SHALL be sampled on edge E0+LATENCY+1, then the FSM SHALL enter RESP.
REQ-022 On the sampling edge: rsp_sum<=res_in, rsp_carry<=bit 8 of 9-bit A+B, rsp_mismatch<=(res_in != A+B mod 256); rsp_valid high from that edge on.
REQ-023 In RESP, rsp_valid and all rsp_* SHALL hold stable until rsp_valid&rsp_ready; that edge returns to IDLE with rsp_valid low.
REQ-024 op_a/op_b SHALL hold their value from E0 until the next accepted command (no glitch between transactions).
REQ-025 Minimum transaction period SHALL be LATENCY+3 cycles; no command SHALL be accepted while busy.
REQ-026 cmd_valid while busy SHALL be ignored; the command is not lost only if the source holds it (valid/ready rule).

Reset
REQ-027 With rst_n low at a rising edge: state IDLE, op_a=op_b=0, rsp_sum=0, rsp_carry=0, rsp_mismatch=0, rsp_valid=0, busy=0, cmd_ready=0, err_count=0.
REQ-028 Reset during WAIT or RESP SHALL abandon the transaction with no response; cmd_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-029 With ADDER_DRV_ERRCNT_EN defined, err_count SHALL increment by 1 on each sampling edge with mismatch, saturating at 255.
REQ-030 err_clr SHALL zero err_count on the next edge; err_clr coinciding with an increment SHALL yield 0.
REQ-031 Without ADDER_DRV_ERRCNT_EN, err_count SHALL be constant 0, err_clr ignored, no counter flops.

Verification
REQ-032 LATENCY=1, correct adder model, A=0x12 B=0x34 -> rsp_valid 2 cycles after E0, rsp_sum=0x46, carry=0, mismatch=0.
REQ-033 A=0xFF B=0x01, correct model -> rsp_sum=0x00, carry=1, mismatch=0, err_count unchanged.
REQ-034 Faulty model returning 0x47 for 0x12+0x34 (ERRCNT_EN) -> mismatch=1, err_count=1.
REQ-035 rsp_ready low 5 cycles in RESP with cmd_valid high -> rsp_* stable, cmd_ready=0, exactly one accept after handshake.
REQ-036 rst_n low one cycle during WAIT -> no rsp_valid ever, all outputs 0, cmd_ready=1 next cycle.
REQ-037 260 forced mismatches then err_clr coincident with a mismatch -> err_count 255 held, then 0.
